// File: rtl/cpu_pkg.sv
// Shared loader definitions: memory depth, loader FSM states, write-port bundle.
package cpu_pkg;

  localparam int ROM_SIZE = 32;

  typedef enum logic [2:0] {
    IDLE, LEN_HI, LEN_LO, DATA, FILL, DONE, ERR
  } ld_state_e;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_wr_t;

  // Word index to byte address.
  function automatic logic [31:0] word_to_byte_addr(input logic [29:0] idx);
    return {idx, 2'b00};
  endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Big-endian byte-to-word packer: first byte lands in bits 31:24.
module byte_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [23:0] sh_q, sh_d;
  logic [1:0]  cnt_q, cnt_d;

  // The 4th byte completes the word directly from the input, without an extra register stage.
  assign word_valid = in_valid && (cnt_q == 2'd3);
  assign word       = {sh_q, in_byte};

  // Shift and count accepted bytes. A clear drops any partial word.
  always_comb begin
    sh_d  = sh_q;
    cnt_d = cnt_q;
    if (clr) begin
      sh_d  = '0;
      cnt_d = '0;
    end else if (in_valid) begin
      sh_d  = {sh_q[15:0], in_byte};
      cnt_d = cnt_q + 2'd1;
    end
  end

  // Packer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q  <= '0;
      cnt_q <= '0;
    end else begin
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: frames a length-prefixed byte stream into instruction-memory
// word writes, zero-fills the rest of the memory, and holds the CPU in reset meanwhile.
module imem_loader #(
  parameter int ROM_SIZE = cpu_pkg::ROM_SIZE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);
  import cpu_pkg::*;

  localparam int              IDX_W    = $clog2(ROM_SIZE) + 1;
  localparam logic [16:0]     ROM_N    = 17'(ROM_SIZE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROM_SIZE - 1);

  ld_state_e        state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [15:0]      len_q, len_d;
  mem_wr_t          wr_q, wr_d;
  logic             hold_q, hold_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic        pk_clr, pk_valid, pk_word_valid;
  logic [31:0] pk_word;
  logic [15:0] len_rx;
  logic        last_word;

  // Full length as it completes with the low byte on the input.
  assign len_rx    = {len_q[15:8], byte_data};
  assign last_word = (17'(idx_q) + 17'd1) == {1'b0, len_q};

  // Packer only sees bytes in DATA, and restarts on every state change.
  assign pk_valid = byte_valid && (state_q == DATA);
  assign pk_clr   = (state_d != state_q);

  byte_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (pk_clr),
    .in_valid   (pk_valid),
    .in_byte    (byte_data),
    .word_valid (pk_word_valid),
    .word       (pk_word)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (start) state_d = LEN_HI;
      LEN_HI: if (byte_valid) state_d = LEN_LO;
      LEN_LO: if (byte_valid) begin
                if ({1'b0, len_rx} > ROM_N) state_d = ERR;
                else if (len_rx == 16'd0)   state_d = FILL;
                else                        state_d = DATA;
              end
      DATA:   if (pk_word_valid && last_word)
                state_d = ({1'b0, len_q} == ROM_N) ? DONE : FILL;
      FILL:   if (idx_q == LAST_IDX) state_d = DONE;
      DONE:   state_d = IDLE;
      ERR:    if (start) state_d = LEN_HI;
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath next values. Hold and error follow the next state so
  // they change in the cycle the state does; done trails the final write by a cycle.
  always_comb begin
    idx_d    = idx_q;
    len_d    = len_q;
    wr_d     = wr_q;
    wr_d.we  = 1'b0;
    hold_d   = (state_d != IDLE);
    done_d   = (state_q == DONE);
    err_d    = (state_d == ERR);
    case (state_q)
      LEN_HI: if (byte_valid) len_d[15:8] = byte_data;
      LEN_LO: if (byte_valid) begin
                len_d[7:0] = byte_data;
                idx_d      = '0;
              end
      DATA:   if (pk_word_valid) begin
                wr_d.we    = 1'b1;
                wr_d.addr  = word_to_byte_addr(30'(idx_q));
                wr_d.wdata = pk_word;
                idx_d      = idx_q + 1'b1;
              end
      FILL:   begin
                wr_d.we    = 1'b1;
                wr_d.addr  = word_to_byte_addr(30'(idx_q));
                wr_d.wdata = '0;
                idx_d      = idx_q + 1'b1;
              end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      len_q  <= '0;
      wr_q   <= '0;
      hold_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      len_q  <= len_d;
      wr_q   <= wr_d;
      hold_q <= hold_d;
      done_q <= done_d;
      err_q  <= err_d;
    end
  end

  assign mem_we    = wr_q.we;
  assign mem_addr  = wr_q.addr;
  assign mem_wdata = wr_q.wdata;
  assign cpu_hold  = hold_q;
  assign done      = done_q;
  assign error     = err_q;

endmodule
